pipeline_ctrl: RTL and testbench

Central hazard controller for the 5-stage RV32I core (fetch, decode, execute/ALU, memory, writeback). Each cycle it decides which stage input latches stall, which are flushed to bubbles, and when fetch is redirected. It handles load-use interlocks, taken jumps and branches out of the execute stage, and memory-stage wait states. It is the sole driver of every stage's STALL/FLUSH pair.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/hazard_detect.sv | 32 +++
 rtl/pipeline_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the RV32I pipeline hazard controller:
//               controller state encoding, the register-zero index and the
//               default redirect / memory-timeout parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Hazard controller state encoding
  localparam logic [1:0] c_st_run      = 2'd0;
  localparam logic [1:0] c_st_redirect = 2'd1;
  localparam logic [1:0] c_st_mem_wait = 2'd2;

  // x0 is hard-wired to zero, so it never carries a data dependency
  localparam logic [4:0] c_reg_zero = 5'd0;

  // Parameter defaults for pipeline_ctrl
  localparam int unsigned c_redirect_cycles_def = 2;
  localparam int unsigned c_mem_timeout_def     = 1023;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use compare. Flags a hazard when the
//               execute stage holds a load whose destination (other than x0)
//               is a source register of the valid instruction in decode.
// Revision    : 1.0 - initial release
// Ports       : i_d_valid, i_d_reg_s1, i_d_reg_s2  decode-stage instruction
//               i_a_valid, i_a_load_rden, i_a_reg_d execute-stage instruction
//               o_hazard                            load-use hazard present
// ============================================================================
module hazard_detect
  import cpu_pkg::*;
(
  input  logic       i_d_valid,
  input  logic [4:0] i_d_reg_s1,
  input  logic [4:0] i_d_reg_s2,
  input  logic       i_a_valid,
  input  logic       i_a_load_rden,
  input  logic [4:0] i_a_reg_d,
  output logic       o_hazard
);

  logic w_src_match;

  assign w_src_match = (i_d_reg_s1 == i_a_reg_d) || (i_d_reg_s2 == i_a_reg_d);

  assign o_hazard = i_a_valid && i_a_load_rden && (i_a_reg_d != c_reg_zero) &&
                    i_d_valid && w_src_match;

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Central hazard controller for the 5-stage RV32I core. Drives
//               every stage STALL/FLUSH pair and the fetch redirect, handling
//               memory wait states, taken jumps out of execute and load-use
//               interlocks (priority in that order).
// Revision    : 1.0 - initial release
// Config      : PIPELINE_CTRL_PERF_EN - when defined, builds the saturating
//               stall / flush performance counters; otherwise both counter
//               ports are tied to zero.
// Ports       : CLK, RST                 clock, synchronous active-high reset
//               D_VALID, D_REG_S1/S2     decode-stage instruction
//               A_VALID, A_REG_D,
//               A_LOAD_RDEN, A_DO_JMP,
//               A_NEW_PC                 execute-stage instruction
//               MEM_BUSY                 memory stage waiting on the bus
//               *_STALL / *_FLUSH        per-stage hold / bubble controls
//               PC_SET, PC_NEW           fetch redirect
//               MEM_ERR                  sticky memory-timeout flag
//               PERF_STALL_CNT/FLUSH_CNT performance counters
// ============================================================================
module pipeline_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned REDIRECT_CYCLES = c_redirect_cycles_def,
  parameter int unsigned MEM_TIMEOUT     = c_mem_timeout_def
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        D_VALID,
  input  logic [4:0]  D_REG_S1,
  input  logic [4:0]  D_REG_S2,
  input  logic        A_VALID,
  input  logic [4:0]  A_REG_D,
  input  logic        A_LOAD_RDEN,
  input  logic        A_DO_JMP,
  input  logic [31:0] A_NEW_PC,
  input  logic        MEM_BUSY,
  output logic        F_STALL,
  output logic        D_STALL,
  output logic        A_STALL,
  output logic        M_STALL,
  output logic        W_STALL,
  output logic        D_FLUSH,
  output logic        A_FLUSH,
  output logic        M_FLUSH,
  output logic        W_FLUSH,
  output logic        PC_SET,
  output logic [31:0] PC_NEW,
  output logic        MEM_ERR,
  output logic [31:0] PERF_STALL_CNT,
  output logic [31:0] PERF_FLUSH_CNT
);

  localparam logic [2:0]  c_rd_reload    = 3'(REDIRECT_CYCLES - 1);
  localparam logic [15:0] c_timeout      = 16'(MEM_TIMEOUT);
  localparam logic        c_use_redirect = (REDIRECT_CYCLES > 1);

  logic [1:0]  r_state;
  logic [1:0]  r_prior;
  logic [2:0]  r_rd_cnt;
  logic [15:0] r_to_cnt;
  logic        r_mem_err;

  logic [1:0]  w_state_nxt;
  logic [1:0]  w_prior_nxt;
  logic [2:0]  w_rd_cnt_nxt;
  logic [15:0] w_to_cnt_nxt;
  logic        w_mem_err_nxt;
  logic [1:0]  w_eff_state;
  logic        w_jump;
  logic        w_hazard;
  logic        w_f_stall, w_d_stall, w_a_stall, w_m_stall;
  logic        w_d_flush, w_a_flush, w_w_flush;
  logic        w_pc_set;

  hazard_detect u_hazard_detect (
    .i_d_valid     (D_VALID),
    .i_d_reg_s1    (D_REG_S1),
    .i_d_reg_s2    (D_REG_S2),
    .i_a_valid     (A_VALID),
    .i_a_load_rden (A_LOAD_RDEN),
    .i_a_reg_d     (A_REG_D),
    .o_hazard      (w_hazard)
  );

  assign w_jump = A_VALID && A_DO_JMP;

  // Once the bus releases, the cycle behaves as the state that was
  // interrupted, so a jump or redirect parked behind MEM_BUSY resumes here.
  assign w_eff_state = (r_state == c_st_mem_wait) ? r_prior : r_state;

  always_comb begin
    w_f_stall     = 1'b0;
    w_d_stall     = 1'b0;
    w_a_stall     = 1'b0;
    w_m_stall     = 1'b0;
    w_d_flush     = 1'b0;
    w_a_flush     = 1'b0;
    w_w_flush     = 1'b0;
    w_pc_set      = 1'b0;
    w_state_nxt   = c_st_run;
    w_prior_nxt   = r_prior;
    w_rd_cnt_nxt  = r_rd_cnt;
    w_to_cnt_nxt  = '0;
    w_mem_err_nxt = r_mem_err;

    if (MEM_BUSY) begin
      w_f_stall    = 1'b1;
      w_d_stall    = 1'b1;
      w_a_stall    = 1'b1;
      w_m_stall    = 1'b1;
      w_w_flush    = 1'b1;
      w_state_nxt  = c_st_mem_wait;
      w_prior_nxt  = w_eff_state;
      w_to_cnt_nxt = (r_to_cnt == 16'hFFFF) ? r_to_cnt : r_to_cnt + 16'd1;
      if (w_to_cnt_nxt >= c_timeout) begin
        w_mem_err_nxt = 1'b1;
      end
    end else if (w_jump) begin
      w_pc_set  = 1'b1;
      w_d_flush = 1'b1;
      w_a_flush = 1'b1;
      if (c_use_redirect) begin
        w_state_nxt  = c_st_redirect;
        w_rd_cnt_nxt = c_rd_reload;
      end else begin
        w_rd_cnt_nxt = '0;
      end
    end else if (w_eff_state == c_st_redirect) begin
      // Wrong-path instructions still arriving from fetch are squashed.
      w_d_flush = 1'b1;
      if (r_rd_cnt <= 3'd1) begin
        w_rd_cnt_nxt = '0;
      end else begin
        w_state_nxt  = c_st_redirect;
        w_rd_cnt_nxt = r_rd_cnt - 3'd1;
      end
    end else if (w_hazard) begin
      // Hold fetch/decode one cycle and bubble execute; the load moves on.
      w_f_stall = 1'b1;
      w_d_stall = 1'b1;
      w_a_flush = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= c_st_run;
      r_prior   <= c_st_run;
      r_rd_cnt  <= '0;
      r_to_cnt  <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_prior   <= w_prior_nxt;
      r_rd_cnt  <= w_rd_cnt_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      r_mem_err <= w_mem_err_nxt;
    end
  end

  // Every output is forced low while RST is held.
  assign F_STALL = ~RST & w_f_stall;
  assign D_STALL = ~RST & w_d_stall;
  assign A_STALL = ~RST & w_a_stall;
  assign M_STALL = ~RST & w_m_stall;
  assign W_STALL = 1'b0;
  assign D_FLUSH = ~RST & w_d_flush;
  assign A_FLUSH = ~RST & w_a_flush;
  assign M_FLUSH = 1'b0;
  assign W_FLUSH = ~RST & w_w_flush;
  assign PC_SET  = ~RST & w_pc_set;
  assign PC_NEW  = (~RST & w_pc_set) ? A_NEW_PC : 32'd0;
  assign MEM_ERR = ~RST & r_mem_err;

`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;
  logic        w_lu_bubble;

  // Execute is flushed only by a jump or a load-use bubble.
  assign w_lu_bubble = w_a_flush & ~w_pc_set;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_f_stall && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if ((w_pc_set || w_lu_bubble) && (r_perf_flush != 32'hFFFF_FFFF)) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign PERF_STALL_CNT = RST ? 32'd0 : r_perf_stall;
  assign PERF_FLUSH_CNT = RST ? 32'd0 : r_perf_flush;
`else
  assign PERF_STALL_CNT = 32'd0;
  assign PERF_FLUSH_CNT = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl (REDIRECT_CYCLES=2,
//               MEM_TIMEOUT=1023). Per-cycle vectors carry inputs and the
//               expected outputs; expectations go through a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_valid;
  logic [4:0]  d_reg_s1, d_reg_s2;
  logic        a_valid;
  logic [4:0]  a_reg_d;
  logic        a_load_rden, a_do_jmp;
  logic [31:0] a_new_pc;
  logic        mem_busy;
  logic        f_stall, d_stall, a_stall, m_stall, w_stall;
  logic        d_flush, a_flush, m_flush, w_flush;
  logic        pc_set;
  logic [31:0] pc_new;
  logic        mem_err;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .REDIRECT_CYCLES (2),
    .MEM_TIMEOUT     (1023)
  ) dut (
    .CLK            (clk),
    .RST            (rst),
    .D_VALID        (d_valid),
    .D_REG_S1       (d_reg_s1),
    .D_REG_S2       (d_reg_s2),
    .A_VALID        (a_valid),
    .A_REG_D        (a_reg_d),
    .A_LOAD_RDEN    (a_load_rden),
    .A_DO_JMP       (a_do_jmp),
    .A_NEW_PC       (a_new_pc),
    .MEM_BUSY       (mem_busy),
    .F_STALL        (f_stall),
    .D_STALL        (d_stall),
    .A_STALL        (a_stall),
    .M_STALL        (m_stall),
    .W_STALL        (w_stall),
    .D_FLUSH        (d_flush),
    .A_FLUSH        (a_flush),
    .M_FLUSH        (m_flush),
    .W_FLUSH        (w_flush),
    .PC_SET         (pc_set),
    .PC_NEW         (pc_new),
    .MEM_ERR        (mem_err),
    .PERF_STALL_CNT (perf_stall_cnt),
    .PERF_FLUSH_CNT (perf_flush_cnt)
  );

  // stall = {F,D,A,M,W}, flush = {D,A,M,W}
  typedef struct packed {
    logic [4:0]  stall;
    logic [3:0]  flush;
    logic        pcset;
    logic [31:0] pcnew;
    logic        err;
  } out_t;

  typedef struct {
    string       name;
    logic        rst;
    logic        dv;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic        av;
    logic [4:0]  rd;
    logic        ld;
    logic        jmp;
    logic [31:0] pc;
    logic        busy;
    out_t        exp;
  } vec_t;

  typedef struct {
    string name;
    out_t  exp;
  } sb_t;

  localparam logic [4:0] S_NO = 5'b00000;
  localparam logic [4:0] S_LU = 5'b11000;
  localparam logic [4:0] S_BZ = 5'b11110;
  localparam logic [3:0] F_NO = 4'b0000;
  localparam logic [3:0] F_LU = 4'b0100;
  localparam logic [3:0] F_JP = 4'b1100;
  localparam logic [3:0] F_RD = 4'b1000;
  localparam logic [3:0] F_BZ = 4'b0001;

  int   passed = 0;
  int   total  = 0;
  sb_t  sb[$];
  vec_t tbl[30];

  function automatic vec_t mk(input string name, input logic r, input logic dv,
                              input logic [4:0] s1, input logic [4:0] s2,
                              input logic av, input logic [4:0] rd,
                              input logic ld, input logic jmp,
                              input logic [31:0] pc, input logic busy,
                              input logic [4:0] st, input logic [3:0] fl,
                              input logic ps, input logic [31:0] pn,
                              input logic er);
    vec_t v;
    v.name = name; v.rst = r; v.dv = dv; v.s1 = s1; v.s2 = s2;
    v.av = av; v.rd = rd; v.ld = ld; v.jmp = jmp; v.pc = pc; v.busy = busy;
    v.exp.stall = st; v.exp.flush = fl; v.exp.pcset = ps;
    v.exp.pcnew = pn; v.exp.err = er;
    return v;
  endfunction

  function automatic out_t observe();
    out_t o;
    o.stall = {f_stall, d_stall, a_stall, m_stall, w_stall};
    o.flush = {d_flush, a_flush, m_flush, w_flush};
    o.pcset = pc_set;
    o.pcnew = pc_new;
    o.err   = mem_err;
    return o;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, check at negedge.
  task automatic step(input vec_t v);
    sb_t  e;
    out_t a;
    rst = v.rst; d_valid = v.dv; d_reg_s1 = v.s1; d_reg_s2 = v.s2;
    a_valid = v.av; a_reg_d = v.rd; a_load_rden = v.ld; a_do_jmp = v.jmp;
    a_new_pc = v.pc; mem_busy = v.busy;
    sb.push_back('{name: v.name, exp: v.exp});
    @(negedge clk);
    a = observe();
    total++;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      e = sb.pop_front();
      if (a !== e.exp) begin
        $display("FAIL %s: got stall=%b flush=%b pc_set=%b pc_new=%h err=%b, expected stall=%b flush=%b pc_set=%b pc_new=%h err=%b",
                 e.name, a.stall, a.flush, a.pcset, a.pcnew, a.err,
                 e.exp.stall, e.exp.flush, e.exp.pcset, e.exp.pcnew, e.exp.err);
      end else begin
        passed++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string name, input logic [31:0] act,
                         input logic [31:0] req);
    total++;
    if (act !== req) begin
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end else begin
      passed++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_stall_cnt;
    logic [31:0] exp_flush_cnt;

    // name, rst, dv, s1, s2, av, rd, ld, jmp, pc, busy | stall, flush, pcset, pcnew, err
    tbl[0]  = mk("rst_jump_lu",    1, 1, 5, 7, 1, 5, 1, 1, 32'h100, 0, S_NO, F_NO, 0, 0, 0);
    tbl[1]  = mk("rst_busy",       1, 0, 0, 0, 0, 0, 0, 0, 0,       1, S_NO, F_NO, 0, 0, 0);
    tbl[2]  = mk("idle",           0, 0, 0, 0, 0, 0, 0, 0, 0,       0, S_NO, F_NO, 0, 0, 0);
    tbl[3]  = mk("lu_rs1",         0, 1, 5, 7, 1, 5, 1, 0, 0,       0, S_LU, F_LU, 0, 0, 0);
    tbl[4]  = mk("lu_release",     0, 1, 5, 7, 0, 0, 0, 0, 0,       0, S_NO, F_NO, 0, 0, 0);
    tbl[5]  = mk("lu_x0",          0, 1, 0, 7, 1, 0, 1, 0, 0,       0, S_NO, F_NO, 0, 0, 0);
    tbl[6]  = mk("lu_rs2",         0, 1, 3, 9, 1, 9, 1, 0, 0,       0, S_LU, F_LU, 0, 0, 0);
    tbl[7]  = mk("lu_d_invalid",   0, 0, 5, 7, 1, 5, 1, 0, 0,       0, S_NO, F_NO, 0, 0, 0);
    tbl[8]  = mk("jump",           0, 0, 0, 0, 1, 1, 0, 1, 32'h100, 0, S_NO, F_JP, 1, 32'h100, 0);
    tbl[9]  = mk("redir_lu_supp",  0, 1, 5, 7, 1, 5, 1, 0, 32'hDEAD, 0, S_NO, F_RD, 0, 0, 0);
    tbl[10] = mk("run_after_redir",0, 1, 5, 7, 1, 5, 1, 0, 0,       0, S_LU, F_LU, 0, 0, 0);
    tbl[11] = mk("jump_and_lu",    0, 1, 5, 7, 1, 5, 1, 1, 32'h200, 0, S_NO, F_JP, 1, 32'h200, 0);
    tbl[12] = mk("rejump",         0, 0, 0, 0, 1, 1, 0, 1, 32'h300, 0, S_NO, F_JP, 1, 32'h300, 0);
    tbl[13] = mk("rejump_redir",   0, 0, 0, 0, 0, 0, 0, 0, 0,       0, S_NO, F_RD, 0, 0, 0);
    tbl[14] = mk("redir_done",     0, 0, 0, 0, 0, 0, 0, 0, 0,       0, S_NO, F_NO, 0, 0, 0);
    tbl[15] = mk("busy_jump_1",    0, 0, 0, 0, 1, 1, 0, 1, 32'h400, 1, S_BZ, F_BZ, 0, 0, 0);
    tbl[16] = mk("busy_jump_2",    0, 0, 0, 0, 1, 1, 0, 1, 32'h400, 1, S_BZ, F_BZ, 0, 0, 0);
    tbl[17] = mk("busy_jump_3",    0, 0, 0, 0, 1, 1, 0, 1, 32'h400, 1, S_BZ, F_BZ, 0, 0, 0);
    tbl[18] = mk("jump_after_busy",0, 0, 0, 0, 1, 1, 0, 1, 32'h400, 0, S_NO, F_JP, 1, 32'h400, 0);
    tbl[19] = mk("busy_in_redir",  0, 0, 0, 0, 0, 0, 0, 0, 0,       1, S_BZ, F_BZ, 0, 0, 0);
    tbl[20] = mk("redir_resume",   0, 0, 0, 0, 0, 0, 0, 0, 0,       0, S_NO, F_RD, 0, 0, 0);
    tbl[21] = mk("redir_end",      0, 0, 0, 0, 0, 0, 0, 0, 0,       0, S_NO, F_NO, 0, 0, 0);
    tbl[22] = mk("busy_over_lu",   0, 1, 5, 7, 1, 5, 1, 0, 0,       1, S_BZ, F_BZ, 0, 0, 0);
    tbl[23] = mk("lu_after_busy",  0, 1, 5, 7, 1, 5, 1, 0, 0,       0, S_LU, F_LU, 0, 0, 0);
    tbl[24] = mk("jump_pre_rst",   0, 0, 0, 0, 1, 1, 0, 1, 32'h500, 0, S_NO, F_JP, 1, 32'h500, 0);
    tbl[25] = mk("rst_in_redir",   1, 0, 0, 0, 0, 0, 0, 0, 0,       0, S_NO, F_NO, 0, 0, 0);
    tbl[26] = mk("no_resid_flush", 0, 0, 0, 0, 0, 0, 0, 0, 0,       0, S_NO, F_NO, 0, 0, 0);
    tbl[27] = mk("busy_pre_rst",   0, 0, 0, 0, 0, 0, 0, 0, 0,       1, S_BZ, F_BZ, 0, 0, 0);
    tbl[28] = mk("rst_in_memwait", 1, 0, 0, 0, 0, 0, 0, 0, 0,       1, S_NO, F_NO, 0, 0, 0);
    tbl[29] = mk("run_after_rst",  0, 1, 5, 7, 1, 5, 1, 0, 0,       0, S_LU, F_LU, 0, 0, 0);

    rst = 1'b1; d_valid = 1'b0; d_reg_s1 = '0; d_reg_s2 = '0; a_valid = 1'b0;
    a_reg_d = '0; a_load_rden = 1'b0; a_do_jmp = 1'b0; a_new_pc = '0;
    mem_busy = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 30; i++) begin
      step(tbl[i]);
    end

    // Memory timeout: 1023 busy cycles; the flag registers at the end of the
    // 1023rd and is visible from the following cycle.
    for (int i = 0; i < 1023; i++) begin
      step(mk("timeout_busy", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, S_BZ, F_BZ, 0, 0, 0));
    end
    step(mk("err_set",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_NO, F_NO, 0, 0, 1));
    step(mk("err_sticky",   0, 1, 5, 7, 1, 5, 1, 0, 0, 0, S_LU, F_LU, 0, 0, 1));
    step(mk("err_busy",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, S_BZ, F_BZ, 0, 0, 1));
    step(mk("err_hold",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_NO, F_NO, 0, 0, 1));
    step(mk("err_rst",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_NO, F_NO, 0, 0, 0));
    step(mk("err_cleared",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_NO, F_NO, 0, 0, 0));

    // Performance counters: 4 load-use bubbles and 2 jumps since the reset.
    for (int i = 0; i < 4; i++) begin
      step(mk("perf_lu",      0, 1, 5, 7, 1, 5, 1, 0, 0, 0, S_LU, F_LU, 0, 0, 0));
      step(mk("perf_lu_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_NO, F_NO, 0, 0, 0));
    end
    for (int i = 0; i < 2; i++) begin
      step(mk("perf_jump",    0, 0, 0, 0, 1, 1, 0, 1, 32'h40, 0, S_NO, F_JP, 1, 32'h40, 0));
      step(mk("perf_redir",   0, 0, 0, 0, 0, 0, 0, 0, 0,      0, S_NO, F_RD, 0, 0, 0));
      step(mk("perf_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0,      0, S_NO, F_NO, 0, 0, 0));
    end
`ifdef PIPELINE_CTRL_PERF_EN
    exp_stall_cnt = 32'd4;
    exp_flush_cnt = 32'd6;
`else
    exp_stall_cnt = 32'd0;
    exp_flush_cnt = 32'd0;
`endif
    check32("perf_stall_cnt", perf_stall_cnt, exp_stall_cnt);
    check32("perf_flush_cnt", perf_flush_cnt, exp_flush_cnt);

    step(mk("perf_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_NO, F_NO, 0, 0, 0));
    check32("perf_stall_rst", perf_stall_cnt, 32'd0);
    check32("perf_flush_rst", perf_flush_cnt, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
